// File: rtl/cia_pkg.sv
// Shared types and constants for the CIA time-of-day block.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package cia_pkg;

  // CPU-visible TOD register index (reg_sel encoding)
  typedef enum logic [1:0] {
    TOD_TEN = 2'd0,
    TOD_SEC = 2'd1,
    TOD_MIN = 2'd2,
    TOD_HR  = 2'd3
  } tod_reg_e;

  // Carry ripple sequencer states, one register updated per state
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TEN  = 3'd1,
    ST_SEC  = 3'd2,
    ST_MIN  = 3'd3,
    ST_HR   = 3'd4
  } tod_fsm_e;

  localparam int TOD_DIV50 = 5;
  localparam int TOD_DIV60 = 6;
  localparam int HR_PM_BIT = 7;

  // Bits that physically exist in each register; the rest store and read as 0
  localparam logic [7:0] TEN_MASK = 8'h0F;
  localparam logic [7:0] SM_MASK  = 8'h7F;
  localparam logic [7:0] HR_MASK  = 8'h9F;

  typedef struct packed {
    logic [7:0] ten;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hr;
  } tod_time_t;

  // 12-hour clock step: 12->01 keeps PM, 11->12 flips PM, 09->10, else units+1
  function automatic logic [7:0] hr_inc(input logic pm, input logic [4:0] v);
    logic [7:0] r;
    if (v == 5'h12)      r = {pm, 2'b00, 5'h01};
    else if (v == 5'h11) r = {~pm, 2'b00, 5'h12};
    else if (v == 5'h09) r = {pm, 2'b00, 5'h10};
    else                 r = {pm, 2'b00, v[4], v[3:0] + 4'h1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_add.sv
// Single BCD digit incrementer: wraps MAX->0 with carry, otherwise +1 mod 2^WID.
// Latency: combinational.
// Backpressure: none.
module bcd_add #(
  parameter int WID = 4,
  parameter int MAX = 9
) (
  input  logic [WID-1:0] din,
  input  logic           cin,
  output logic [WID-1:0] dout,
  output logic           cout
);

  // Out-of-range digits simply count up so corrupted BCD still has defined behaviour
  always_comb begin
    dout = din;
    cout = 1'b0;
    if (cin) begin
      if (din == WID'(MAX)) begin
        dout = '0;
        cout = 1'b1;
      end else begin
        dout = din + WID'(1);
      end
    end
  end

endmodule

// File: rtl/cia_tod_prescale.sv
// TOD pin conditioning and 50/60 Hz divider; emits one tenth-second event pulse.
// Latency: tenth is combinational from tick (tick = tod_in, or +3 cycles with TOD_IN_SYNC_EN).
// Backpressure: none; clr overrides counting and suppresses the event that cycle.
module cia_tod_prescale import cia_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic tod_in,
  input  logic cra_todin,
  input  logic run,
  input  logic clr,
  output logic tenth
);

  logic       tick;
  logic [2:0] cnt;
  logic [2:0] div_m1;

`ifdef TOD_IN_SYNC_EN
  logic [2:0] sync_q;
  logic       tick_q;

  // Two-flop synchroniser, one history flop, registered rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], tod_in};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign tick = tick_q;
`else
  assign tick = tod_in;
`endif

  // Divider selection is sampled live so a CRA7 change applies at the next compare
  assign div_m1 = cra_todin ? 3'(TOD_DIV50 - 1) : 3'(TOD_DIV60 - 1);
  assign tenth  = run & tick & ~clr & (cnt == div_m1);

  // Tick counter; a count left above the terminal value by a divider change wraps to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (clr) begin
      cnt <= 3'd0;
    end else if (run && tick) begin
      cnt <= (cnt >= div_m1) ? 3'd0 : cnt + 3'd1;
    end
  end

endmodule

// File: rtl/cia_tod_ctrl.sv
// CIA time-of-day: BCD carry ripple, halt-on-write, latch-on-read and alarm compare.
// Latency: tenth event -> tenths 1 cycle, full ripple 4 cycles; rdata 1 cycle after re.
// Backpressure: none; we/re accepted every cycle. Build option: TOD_IN_SYNC_EN.
module cia_tod_ctrl import cia_pkg::*; #(
  parameter logic [7:0] HR_RST = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tod_in,
  input  logic       cra_todin,
  input  logic       crb_alarm,
  input  logic [1:0] reg_sel,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       alarm
);

  tod_reg_e  sel;
  tod_fsm_e  state, state_nxt;
  tod_time_t cur, cur_nxt, alm, latch;
  logic      stopped, latched, pending, pending_nxt, match, match_q, tenth;
  logic      wr_time, wr_alm, wr_ten, wr_sec, wr_min, wr_hr;

  logic [3:0] ten_sum, secu_sum, minu_sum;
  logic [2:0] sect_sum, mint_sum;
  logic       ten_co, secu_co, sect_co, minu_co, mint_co;

  assign sel     = tod_reg_e'(reg_sel);
  assign wr_time = we & ~crb_alarm;
  assign wr_alm  = we & crb_alarm;
  assign wr_ten  = wr_time & (sel == TOD_TEN);
  assign wr_sec  = wr_time & (sel == TOD_SEC);
  assign wr_min  = wr_time & (sel == TOD_MIN);
  assign wr_hr   = wr_time & (sel == TOD_HR);

  cia_tod_prescale u_prescale (
    .clk       (clk),
    .rst       (rst),
    .tod_in    (tod_in),
    .cra_todin (cra_todin),
    .run       (~stopped),
    .clr       (wr_ten | wr_hr),
    .tenth     (tenth)
  );

  // Digit incrementers; each state only ever advances its register by one
  bcd_add #(.WID(4), .MAX(9)) u_ten  (.din(cur.ten[3:0]), .cin(1'b1),    .dout(ten_sum),  .cout(ten_co));
  bcd_add #(.WID(4), .MAX(9)) u_secu (.din(cur.sec[3:0]), .cin(1'b1),    .dout(secu_sum), .cout(secu_co));
  bcd_add #(.WID(3), .MAX(5)) u_sect (.din(cur.sec[6:4]), .cin(secu_co), .dout(sect_sum), .cout(sect_co));
  bcd_add #(.WID(4), .MAX(9)) u_minu (.din(cur.min[3:0]), .cin(1'b1),    .dout(minu_sum), .cout(minu_co));
  bcd_add #(.WID(3), .MAX(5)) u_mint (.din(cur.min[6:4]), .cin(minu_co), .dout(mint_sum), .cout(mint_co));

  // Ripple sequencing and CPU write merge; a CPU write to the register being stepped wins
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cur_nxt     = cur;
    if (tenth && (state != ST_IDLE)) pending_nxt = 1'b1;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_nxt   = ST_TEN;
          pending_nxt = 1'b0;
        end else if (tenth) begin
          state_nxt = ST_TEN;
        end
      end
      ST_TEN: begin
        cur_nxt.ten = {4'h0, ten_sum};
        state_nxt   = (ten_co && !wr_ten) ? ST_SEC : ST_IDLE;
      end
      ST_SEC: begin
        cur_nxt.sec = {1'b0, sect_sum, secu_sum};
        state_nxt   = (sect_co && !wr_sec) ? ST_MIN : ST_IDLE;
      end
      ST_MIN: begin
        cur_nxt.min = {1'b0, mint_sum, minu_sum};
        state_nxt   = (mint_co && !wr_min) ? ST_HR : ST_IDLE;
      end
      ST_HR: begin
        cur_nxt.hr = hr_inc(cur.hr[HR_PM_BIT], cur.hr[4:0]);
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (wr_ten) cur_nxt.ten = wdata & TEN_MASK;
    if (wr_sec) cur_nxt.sec = wdata & SM_MASK;
    if (wr_min) cur_nxt.min = wdata & SM_MASK;
    if (wr_hr) begin
      cur_nxt.hr  = wdata & HR_MASK;
      state_nxt   = ST_IDLE;
      pending_nxt = 1'b0;
    end
  end

  // Carry sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Time registers, queued tenth event and run/stop (hours write halts, tenths write restarts)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= '{ten: 8'h00, sec: 8'h00, min: 8'h00, hr: HR_RST};
      pending <= 1'b0;
      stopped <= 1'b1;
    end else begin
      cur     <= cur_nxt;
      pending <= pending_nxt;
      if (wr_hr)       stopped <= 1'b1;
      else if (wr_ten) stopped <= 1'b0;
    end
  end

  // Alarm registers are written only when CRB7 redirects TOD writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alm <= '0;
    end else if (wr_alm) begin
      case (sel)
        TOD_TEN: alm.ten <= wdata & TEN_MASK;
        TOD_SEC: alm.sec <= wdata & SM_MASK;
        TOD_MIN: alm.min <= wdata & SM_MASK;
        TOD_HR:  alm.hr  <= wdata & HR_MASK;
      endcase
    end
  end

  // Reads: hours snapshots the whole time, tenths releases it; values are pre-write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= 8'h00;
      latched <= 1'b0;
      latch   <= '0;
    end else if (re) begin
      case (sel)
        TOD_HR: begin
          if (!latched) begin
            latch   <= cur;
            latched <= 1'b1;
            rdata   <= cur.hr;
          end else begin
            rdata <= latch.hr;
          end
        end
        TOD_TEN: begin
          rdata   <= latched ? latch.ten : cur.ten;
          latched <= 1'b0;
        end
        TOD_SEC: rdata <= latched ? latch.sec : cur.sec;
        TOD_MIN: rdata <= latched ? latch.min : cur.min;
      endcase
    end
  end

  assign match = (cur == alm);

  // Alarm fires once on the rising edge of the time/alarm equality
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      match_q <= match;
      alarm   <= match & ~match_q;
    end
  end

endmodule

// File: tb/tb_cia_tod_ctrl.sv
// Directed bench for cia_tod_ctrl: prescaler, ripple, halt, latch, alarm, write priority.
// Latency: n/a.
// Backpressure: n/a.
module tb_cia_tod_ctrl;

  localparam logic [1:0] R_TEN = 2'd0;
  localparam logic [1:0] R_SEC = 2'd1;
  localparam logic [1:0] R_MIN = 2'd2;
  localparam logic [1:0] R_HR  = 2'd3;

  logic       clk = 1'b0;
  logic       rst, tod_in, cra_todin, crb_alarm, we, re, alarm;
  logic [1:0] reg_sel;
  logic [7:0] wdata, rdata;

  int n_checks = 0;
  int n_errors = 0;

  cia_tod_ctrl #(.HR_RST(8'h01)) dut (
    .clk       (clk),
    .rst       (rst),
    .tod_in    (tod_in),
    .cra_todin (cra_todin),
    .crb_alarm (crb_alarm),
    .reg_sel   (reg_sel),
    .we        (we),
    .re        (re),
    .wdata     (wdata),
    .rdata     (rdata),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] d, input logic to_alarm);
    crb_alarm = to_alarm;
    reg_sel   = s;
    wdata     = d;
    we        = 1'b1;
    cyc();
    we        = 1'b0;
    crb_alarm = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] s, input logic [7:0] exp);
    reg_sel = s;
    re      = 1'b1;
    cyc();
    re      = 1'b0;
    chk(tag, {24'h0, rdata}, {24'h0, exp});
  endtask

  // n single-cycle ticks, one idle cycle between them, none after the last
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tod_in = 1'b1;
      cyc();
      tod_in = 1'b0;
      if (i != n - 1) cyc();
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] t);
    wr(R_HR, h, 1'b0);
    wr(R_MIN, m, 1'b0);
    wr(R_SEC, s, 1'b0);
    wr(R_TEN, t, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int pulses;
    int pulse_at;
    rst = 1'b1; tod_in = 1'b0; cra_todin = 1'b0; crb_alarm = 1'b0;
    reg_sel = 2'd0; we = 1'b0; re = 1'b0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_rdata", {24'h0, rdata}, 32'h0);
    chk("rst_alarm", {31'h0, alarm}, 32'h0);
    rd("rst_hr", R_HR, 8'h01);
    rd("rst_min", R_MIN, 8'h00);
    rd("rst_sec", R_SEC, 8'h00);
    rd("rst_ten", R_TEN, 8'h00);

    // stopped out of reset: ticks do nothing
    ticks(6); cyc();
    rd("rst_stopped", R_TEN, 8'h00);

    // 60 Hz: sixth tick makes an event; tenths updates one cycle later
    wr(R_TEN, 8'h00, 1'b0);
    ticks(6);
    rd("div60_before", R_TEN, 8'h00);
    rd("div60_after", R_TEN, 8'h01);

    // 50 Hz: four ticks are not enough, the fifth is
    cra_todin = 1'b1;
    wr(R_TEN, 8'h00, 1'b0);
    ticks(4); cyc();
    rd("div50_four", R_TEN, 8'h00);
    ticks(1);
    rd("div50_before", R_TEN, 8'h00);
    rd("div50_after", R_TEN, 8'h01);
    cra_todin = 1'b0;

    // full ripple 11:59:59.9 AM -> 12:00:00.0 PM, hours steps on the 4th cycle
    set_time(8'h11, 8'h59, 8'h59, 8'h09);
    ticks(6);
    repeat (3) cyc();
    rd("ripple_hr_pre", R_HR, 8'h11);
    rd("ripple_min_lat", R_MIN, 8'h00);
    rd("ripple_ten_rel", R_TEN, 8'h00);
    rd("ripple_hr_pm", R_HR, 8'h92);
    rd("ripple_sec", R_SEC, 8'h00);
    rd("ripple_ten", R_TEN, 8'h00);

    // 12:59:59.9 PM -> 01:00:00.0 PM
    set_time(8'h92, 8'h59, 8'h59, 8'h09);
    ticks(6);
    repeat (4) cyc();
    rd("hr12_to_1", R_HR, 8'h81);
    rd("hr12_ten", R_TEN, 8'h00);

    // hours write halts; tenths write restarts from prescaler 0
    wr(R_TEN, 8'h03, 1'b0);
    wr(R_HR, 8'h05, 1'b0);
    ticks(20); cyc();
    rd("halt_hr", R_HR, 8'h05);
    rd("halt_ten", R_TEN, 8'h03);
    wr(R_TEN, 8'h00, 1'b0);
    ticks(5); cyc();
    rd("resume_five", R_TEN, 8'h00);
    ticks(1); cyc();
    rd("resume_six", R_TEN, 8'h01);

    // latch on hours read survives carries until tenths is read
    set_time(8'h01, 8'h00, 8'h59, 8'h09);
    rd("latch_hr", R_HR, 8'h01);
    ticks(6);
    repeat (5) cyc();
    rd("latch_min", R_MIN, 8'h00);
    rd("latch_sec", R_SEC, 8'h59);
    rd("latch_ten", R_TEN, 8'h09);
    rd("live_sec", R_SEC, 8'h00);
    rd("live_min", R_MIN, 8'h01);

    // read and write together: old value returned, new value stored
    reg_sel = R_SEC; wdata = 8'h12; we = 1'b1; re = 1'b1;
    cyc();
    we = 1'b0; re = 1'b0;
    chk("rw_same_old", {24'h0, rdata}, 32'h00);
    rd("rw_same_new", R_SEC, 8'h12);

    // hours write while latched keeps the snapshot; unused bits masked
    rd("hrw_latch", R_HR, 8'h01);
    wr(R_HR, 8'hE3, 1'b0);
    rd("hrw_kept", R_HR, 8'h01);
    rd("hrw_rel", R_TEN, 8'h00);
    rd("hrw_new", R_HR, 8'h83);
    rd("hrw_rel2", R_TEN, 8'h00);

    // alarm at 01:00:01.0; alarm writes must not halt the clock
    set_time(8'h01, 8'h00, 8'h00, 8'h09);
    wr(R_HR, 8'h01, 1'b1);
    wr(R_MIN, 8'h00, 1'b1);
    wr(R_SEC, 8'h01, 1'b1);
    wr(R_TEN, 8'h00, 1'b1);
    chk("alarm_idle", {31'h0, alarm}, 32'h0);
    ticks(6);
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (alarm) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("alarm_pulses", pulses, 1);
    chk("alarm_cycle", pulse_at, 3);
    rd("alarm_sec", R_SEC, 8'h01);

    // CPU write to sec while SEC state would carry: write wins, no minute carry
    set_time(8'h01, 8'h00, 8'h59, 8'h09);
    ticks(6);
    cyc();
    wr(R_SEC, 8'h7F, 1'b0);
    repeat (3) cyc();
    rd("wwin_sec", R_SEC, 8'h7F);
    rd("wwin_min", R_MIN, 8'h00);
    rd("wwin_ten", R_TEN, 8'h00);

    // invalid units digit F wraps to 0 without carry
    wr(R_TEN, 8'h09, 1'b0);
    ticks(6);
    repeat (5) cyc();
    rd("bad_bcd_sec", R_SEC, 8'h70);
    rd("bad_bcd_min", R_MIN, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cia_tod_ctrl.md
Name: cia_tod_ctrl

Overview:
Time-of-day controller for the CIA. It divides the 50/60 Hz TOD pin into tenth-second events and sequences BCD carry ripple across the tenths, seconds, minutes and hours registers, one register per cycle. It also implements the CPU-visible halt-on-write and latch-on-read semantics, plus alarm compare.
It sits between the CIA register decode and the interrupt control block.

Parameters:
HR_RST, 8'h01, hours register value after reset (1 AM).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tod_in  in  1  TOD input (see Optional Feature)
cra_todin  in  1  CRA7; 1 = 50 Hz (divide by 5), 0 = 60 Hz (divide by 6)
crb_alarm  in  1  CRB7; 1 = TOD writes go to alarm registers
reg_sel  in  2  0 tenths, 1 seconds, 2 minutes, 3 hours
we  in  1  register write strobe, one cycle
re  in  1  register read strobe, one cycle
wdata  in  8  write data
rdata  out  8  read data, registered, valid the cycle after re
alarm  out  1  one-cycle pulse on time==alarm rising match

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-high.
- Reset values: tenths=0, sec=0, min=0, hr=HR_RST. All alarm registers 0. stopped=1, latched=0, prescaler=0, FSM=IDLE, pending=0, match_q=0, rdata=0, alarm=0.
- Register formats:
  - tenths: [3:0].
  - sec and min: [6:4] tens, [3:0] units.
  - hr: [7] PM, [4] tens, [3:0] units.
  - Unused bits are stored as 0 on write and read back as 0.
- Prescaler (3-bit):
  - Counts tick pulses while stopped=0.
  - On reaching div-1 (4 or 6-1=5) with a tick, it returns to 0 and raises a tenth event.
  - A cra_todin change takes effect on the next compare. A count above div-1 wraps to 0 on the next tick.
- Carry FSM:
  - States: IDLE, TEN, SEC, MIN, HR. A tenth event in IDLE goes to TEN.
  - Each state increments its register by 1, or by the carry from the previous state.
  - If the carry out is 1, go to the next state; otherwise go to IDLE. HR always returns to IDLE.
  - Latency from tick to tenths updated: 1 cycle. Worst-case full ripple: 4 cycles.
- Digit rule (bcd_add cells; MAX=9 for units, MAX=5 for sec/min tens):
  - A digit equal to MAX with carry-in becomes 0 and carries out.
  - Any other value increments modulo 2^WID with no carry. This makes invalid BCD values defined.
- Hours rule:
  - 12 -> 01, PM unchanged.
  - 11 -> 12, PM toggles.
  - 09 -> 10.
  - Otherwise the units digit increments.
- Tenth event while the FSM is not IDLE: set pending. The FSM enters TEN from IDLE on the following cycle; a second event while pending is dropped.
- CPU writes (crb_alarm=0):
  - Writing hr: sets stopped=1, clears prescaler and pending, forces FSM to IDLE.
  - Writing tenths: sets stopped=0, clears prescaler.
  - Write vs FSM: a write to the register the FSM updates in the same cycle wins. The FSM treats the carry out as 0 and returns to IDLE.
- Alarm writes (crb_alarm=1): load alarm registers only. No halt and no FSM effect.
- Reads:
  - re on hr with latched=0: copies all four live registers into the latch and sets latched=1. rdata gets live hr.
  - re on tenths: rdata gets the latch copy if latched, else live. Clears latched.
  - Other registers return the latch copy while latched, else live.
  - re and we in the same cycle: the write applies, and rdata returns the pre-write value.
  - Hours write while latched: latch is kept.
- Alarm:
  - match = all four time registers equal the alarm registers (registered compare); match_q <= match.
  - alarm = match & ~match_q, asserted one cycle after the matching state.

Optional Feature:
TOD_IN_SYNC_EN
- Defined: tod_in is asynchronous. A 2-flop synchroniser and rising-edge detector produce tick, adding 3 cycles of latency.
- Undefined: tod_in is a clean single-cycle tick pulse in the clk domain and is used directly.

Decomposition:
- cia_pkg holds:
  - tod_reg_e enum (TOD_TEN, TOD_SEC, TOD_MIN, TOD_HR).
  - tod_fsm_e state enum.
  - Constants TOD_DIV50=5, TOD_DIV60=6, HR_PM_BIT=7.
  - tod_time_t packed struct {ten, sec, min, hr}.
- Digit increments instantiate bcd_add (MAX=9 and MAX=5).
- Natural sub-module: cia_tod_prescale (sync/edge detect plus divider, emits tenth event).

Test Plan:
1. Reset, write tenths=0, 60 Hz, 6 ticks -> tenths=1 one cycle after 6th tick. With 50 Hz, 5 ticks -> tenths=1.
2. Preload 11:59:59.9 AM (hr=0x11, min=0x59, sec=0x59, ten=9), one tenth event -> after 4 cycles 12:00:00.0 with hr=0x92 (PM). Preload 0x92:59:59.9 -> hr=0x81.
3. Write hr=0x05 then tick 20 times -> no change, stopped=1. Write tenths=0 -> counting resumes from prescaler 0.
4. Read hr at 01:00:00.9, let carries occur, read min -> returns latched 0x00. Read tenths -> 9 and latch released. Next read of sec -> live value.
5. Alarm=01:00:01.0 via crb_alarm=1, time 01:00:00.9, one event -> alarm pulses exactly once, one cycle after sec updates. No halt occurs on alarm writes.
6. Write sec=0x7F with carry arriving in SEC state same cycle -> sec=0x7F, FSM returns to IDLE, min unchanged. Next event: tenths ripple carries into sec, giving 0x70 with no carry.
